// File: rtl/nv_nvdla_mcif_pkg.sv
// Shared constants and helpers for the MCIF client read-return path.
package nv_nvdla_mcif_pkg;

  localparam int MCIF_DW        = 64;
  localparam int MCIF_MAX_BEATS = 4;
  localparam int MCIF_LEN_W     = 2;

  // Request length as carried on the ingress side: beats minus one.
  typedef logic [MCIF_LEN_W-1:0] req_len_t;

  // Convert an encoded request length (0..3) into a beat count (1..4).
  function automatic logic [MCIF_LEN_W:0] len_to_beats(input req_len_t len);
    return {1'b0, len} + (MCIF_LEN_W + 1)'(1);
  endfunction

endpackage

// File: rtl/nv_nvdla_mcif_rsp_fifo.sv
// Synchronous return FIFO: wrap-bit pointers, registered occupancy count,
// head entry presented combinationally from storage (no bypass path).
module nv_nvdla_mcif_rsp_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [CNT_W-1:0] occ
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = CNT_W + 1;
  localparam logic [PW-1:0] DEPTH_PW = PW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] ptr_diff;

  // Pointer span is a multiple of DEPTH, so the low bits address storage
  // and the difference gives fill level for the full test.
  assign ptr_diff = wr_ptr - rd_ptr;
  assign full     = (ptr_diff == DEPTH_PW);
  assign empty    = (wr_ptr == rd_ptr);
  assign rd_data  = mem[rd_ptr[AW-1:0]];

  // Pointer and occupancy update.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (nvdla_core_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Data storage write.
  always_ff @(posedge nvdla_core_clk) begin
    // NOTE: storage has no reset; empty/valid gate it, and a reset on a RAM
    // array would prevent it mapping to memory cells.
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/nv_nvdla_mcif_read_eg_rsp9.sv
// Client 9 read-return egress: buffers NOC response beats, delivers them to
// the client, and grants ingress request credit so the FIFO never overflows.
module nv_nvdla_mcif_read_eg_rsp9
  import nv_nvdla_mcif_pkg::*;
#(
  parameter int DW        = MCIF_DW,
  parameter int DEPTH     = 8,
  parameter int MAX_BEATS = MCIF_MAX_BEATS,
  parameter int CNT_W     = 4
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rst,
  input  logic                  noc2eg_rsp9_valid,
  output logic                  noc2eg_rsp9_ready,
  input  logic [DW-1:0]         noc2eg_rsp9_pd,
  output logic                  eg2client9_rsp_valid,
  input  logic                  eg2client9_rsp_ready,
  output logic [DW-1:0]         eg2client9_rsp_pd,
  input  logic                  ig_req9_accept,
  input  logic [MCIF_LEN_W-1:0] ig_req9_len,
  output logic                  eg2ig_req9_allow,
  output logic                  eg_rsp9_err
);

  localparam int PW = CNT_W + 1;
  localparam logic [PW-1:0] DEPTH_PW     = PW'(DEPTH);
  localparam logic [PW-1:0] ALLOW_MAX_PW = PW'(DEPTH - MAX_BEATS);

  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] occ;
  logic [CNT_W-1:0] outs;
  logic             noc_hs;
  logic             cli_hs;
  logic [PW-1:0]    outs_add;
  logic [PW-1:0]    outs_sum;
  logic [PW-1:0]    outs_dec;
  logic [PW-1:0]    outs_nxt;
  logic [PW-1:0]    credits_used;
  logic             err_set;

  assign noc2eg_rsp9_ready    = !fifo_full;
  assign eg2client9_rsp_valid = !fifo_empty;
  assign noc_hs = noc2eg_rsp9_valid && noc2eg_rsp9_ready;
  assign cli_hs = eg2client9_rsp_valid && eg2client9_rsp_ready;

  nv_nvdla_mcif_rsp_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .wr_en          (noc_hs),
    .wr_data        (noc2eg_rsp9_pd),
    .rd_en          (cli_hs),
    .rd_data        (eg2client9_rsp_pd),
    .full           (fifo_full),
    .empty          (fifo_empty),
    .occ            (occ)
  );

  // Allow while beats in flight plus beats buffered leave room for a
  // maximum-length request; written without subtraction so an
  // over-committed state cannot wrap around into a false allow.
  assign credits_used     = {1'b0, occ} + {1'b0, outs};
  assign eg2ig_req9_allow = (credits_used <= ALLOW_MAX_PW);

  // Next outstanding count: add issued beats, retire one per arriving beat,
  // floor at zero on an unexpected beat and cap at DEPTH on over-issue.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    outs_add = '0;
    outs_sum = '0;
    outs_dec = '0;
    outs_nxt = '0;
    err_set  = 1'b0;
    if (ig_req9_accept) outs_add = PW'(len_to_beats(ig_req9_len));
    outs_sum = {1'b0, outs} + outs_add;
    outs_dec = (noc_hs && (outs_sum != '0)) ? outs_sum - PW'(1) : outs_sum;
    outs_nxt = (outs_dec > DEPTH_PW) ? DEPTH_PW : outs_dec;
    err_set  = (noc_hs && (outs == '0)) || (ig_req9_accept && !eg2ig_req9_allow);
  end

  // Outstanding counter register.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) outs <= '0;
    else                outs <= outs_nxt[CNT_W-1:0];
  end

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) eg_rsp9_err <= 1'b0;
    else if (err_set)   eg_rsp9_err <= 1'b1;
  end

endmodule
